mac_tile_sequencer: RTL

Single-clock controller that runs one matrix-vector tile on the MAC datapath. It fills the activation shift memory (IMEM) with K_LEN words from the input FIFO, then issues one MAC operation per weight row. After each operation it pushes the result into the output FIFO, stalling on FIFO empty/full and guarding each MAC with a timeout. It sits between the top-level command logic (start/done) and the FIFO, IMEM and MAC enables.

---
 rtl/mac_tile_sequencer_if.sv | 39 +++
 rtl/mac_tile_sequencer.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/mac_tile_sequencer_if.sv
// Control bundle between the tile sequencer and its FIFO / IMEM / MAC neighbours.
//
// Handshakes: in_read_enable pops the input FIFO and is only raised while
// in_fifo_empty is low (the word is valid one cycle later). out_write_enable
// pushes the output FIFO and is only raised while out_fifo_full is low.
// start_mac is a one-cycle launch and mac_done is the one-cycle completion
// strobe that answers it. start is a level sampled only while the sequencer
// is idle; done is a one-cycle tile-complete pulse.
interface mac_tile_sequencer_if #(
    parameter int ROW_W = 2
);
    logic             start;
    logic             in_fifo_empty;
    logic             in_read_enable;
    logic             imem_shift_enable;
    logic             start_mac;
    logic             mac_done;
    logic [ROW_W-1:0] row_index;
    logic             out_fifo_full;
    logic             out_write_enable;
    logic             busy;
    logic             done;
    logic             timeout_err;
    logic [2:0]       dbg_state;

    // Sequencer side
    modport master (
        input  start, in_fifo_empty, mac_done, out_fifo_full,
        output in_read_enable, imem_shift_enable, start_mac, row_index,
               out_write_enable, busy, done, timeout_err, dbg_state
    );

    // Command logic, FIFOs, IMEM and MAC side
    modport slave (
        output start, in_fifo_empty, mac_done, out_fifo_full,
        input  in_read_enable, imem_shift_enable, start_mac, row_index,
               out_write_enable, busy, done, timeout_err, dbg_state
    );
endinterface

// File: rtl/mac_tile_sequencer.sv
// Tile sequencer: loads K_LEN activation words into IMEM, then runs one MAC
// per weight row, pushing each result to the output FIFO. Each MAC is
// guarded by a timeout that aborts the tile and raises a sticky error.
module mac_tile_sequencer #(
    parameter int K_LEN       = 8,
    parameter int N_ROWS      = 4,
    parameter int ROW_W       = 2,
    parameter int MAC_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    mac_tile_sequencer_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_FILL       = 3'd1,
        S_SHIFT_LAST = 3'd2,
        S_MAC_START  = 3'd3,
        S_MAC_WAIT   = 3'd4,
        S_WRITE      = 3'd5,
        S_DONE       = 3'd6
    } state_t;

    localparam int RD_W = $clog2(K_LEN + 1);
    localparam int WT_W = $clog2(MAC_TIMEOUT + 1);

    localparam logic [RD_W-1:0]  RD_FULL  = RD_W'(K_LEN);
    localparam logic [RD_W-1:0]  RD_LAST  = RD_W'(K_LEN - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(N_ROWS - 1);
    localparam logic [WT_W-1:0]  WT_LAST  = WT_W'(MAC_TIMEOUT - 1);

    state_t           r_state;
    logic [RD_W-1:0]  r_rd_cnt;
    logic [ROW_W-1:0] r_row_cnt;
    logic [ROW_W-1:0] r_row_index;
    logic [WT_W-1:0]  r_wait_cnt;
    logic             r_timeout_err;
    logic             r_shift_en;

    state_t           w_next_state;
    logic [RD_W-1:0]  w_rd_cnt_next;
    logic [ROW_W-1:0] w_row_cnt_next;
    logic [ROW_W-1:0] w_row_index_next;
    logic [WT_W-1:0]  w_wait_cnt_next;
    logic             w_timeout_err_next;
    logic             w_read_en;
    logic             w_write_en;
    logic             w_start_mac;
    logic             w_done;

    // Next-state, counter updates and combinational strobes.
    // row_index is loaded on the transition into MAC_START so it is already
    // valid in the start_mac cycle and holds until the next launch.
    always_comb begin
        w_next_state       = r_state;
        w_rd_cnt_next      = r_rd_cnt;
        w_row_cnt_next     = r_row_cnt;
        w_row_index_next   = r_row_index;
        w_wait_cnt_next    = r_wait_cnt;
        w_timeout_err_next = r_timeout_err;
        w_read_en          = 1'b0;
        w_write_en         = 1'b0;
        w_start_mac        = 1'b0;
        w_done             = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_next_state       = S_FILL;
                    w_rd_cnt_next      = '0;
                    w_row_cnt_next     = '0;
                    w_timeout_err_next = 1'b0;
                end
            end
            S_FILL: begin
                w_read_en = ~bus.in_fifo_empty && (r_rd_cnt < RD_FULL);
                if (w_read_en) begin
                    w_rd_cnt_next = r_rd_cnt + RD_W'(1);
                    if (r_rd_cnt == RD_LAST) begin
                        w_next_state = S_SHIFT_LAST;
                    end
                end
            end
            S_SHIFT_LAST: begin
                w_next_state     = S_MAC_START;
                w_row_index_next = r_row_cnt;
            end
            S_MAC_START: begin
                w_start_mac     = 1'b1;
                w_wait_cnt_next = '0;
                w_next_state    = S_MAC_WAIT;
            end
            S_MAC_WAIT: begin
                if (bus.mac_done) begin
                    w_next_state = S_WRITE;
                end else if (r_wait_cnt == WT_LAST) begin
                    w_timeout_err_next = 1'b1;
                    w_next_state       = S_DONE;
                end else begin
                    w_wait_cnt_next = r_wait_cnt + WT_W'(1);
                end
            end
            S_WRITE: begin
                w_write_en = ~bus.out_fifo_full;
                if (w_write_en) begin
                    if (r_row_cnt == ROW_LAST) begin
                        w_next_state = S_DONE;
                    end else begin
                        w_row_cnt_next   = r_row_cnt + ROW_W'(1);
                        w_row_index_next = r_row_cnt + ROW_W'(1);
                        w_next_state     = S_MAC_START;
                    end
                end
            end
            S_DONE: begin
                w_done       = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // State, counters, sticky error and the one-cycle shift pipeline.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_rd_cnt      <= '0;
            r_row_cnt     <= '0;
            r_row_index   <= '0;
            r_wait_cnt    <= '0;
            r_timeout_err <= 1'b0;
            r_shift_en    <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_rd_cnt      <= w_rd_cnt_next;
            r_row_cnt     <= w_row_cnt_next;
            r_row_index   <= w_row_index_next;
            r_wait_cnt    <= w_wait_cnt_next;
            r_timeout_err <= w_timeout_err_next;
            r_shift_en    <= w_read_en;
        end
    end

    assign bus.in_read_enable    = w_read_en;
    assign bus.imem_shift_enable = r_shift_en;
    assign bus.start_mac         = w_start_mac;
    assign bus.row_index         = r_row_index;
    assign bus.out_write_enable  = w_write_en;
    assign bus.busy              = (r_state != S_IDLE);
    assign bus.done              = w_done;
    assign bus.timeout_err       = r_timeout_err;
    assign bus.dbg_state         = r_state;

endmodule
